// File: rtl/tcpc_pkg.sv
// Shared types and constants for the TCPC register-file access path.
package tcpc_pkg;

    localparam int unsigned REG_DATA_W = 16;
    localparam int unsigned REG_ADDR_W = 8;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A few well-known TCPC register addresses
    localparam logic [REG_ADDR_W-1:0] ADDR_VENDOR_ID     = 8'h00;
    localparam logic [REG_ADDR_W-1:0] ADDR_ALERT         = 8'h10;
    localparam logic [REG_ADDR_W-1:0] ADDR_TCPC_CONTROL  = 8'h19;
    localparam logic [REG_ADDR_W-1:0] ADDR_TRANSMIT      = 8'h50;

    // Command presented to the register file
    typedef struct packed {
        logic                  rnw;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] wdata;
    } reg_cmd_t;

endpackage

// File: rtl/tcpc_reg_arbiter_rr_arbiter.sv
// Round-robin arbiter: owns the last-granted pointer, grants combinationally.
module rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NREQ-1:0]         req,
    input  logic                    update,
    output logic [NREQ-1:0]         gnt_c,
    output logic [$clog2(NREQ)-1:0] gnt_idx_c
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] last_q;

    // Search last+1, last+2, ... modulo NREQ for the first active request
    always_comb begin : rr_search
        int unsigned idx;
        logic        hit;
        gnt_c     = '0;
        gnt_idx_c = '0;
        idx       = 0;
        hit       = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = 32'(last_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!hit && req[IDX_W'(idx)]) begin
                hit       = 1'b1;
                gnt_idx_c = IDX_W'(idx);
            end
        end
        if (hit) begin
            gnt_c[gnt_idx_c] = 1'b1;
        end
    end

    // Pointer resets to NREQ-1 so requester 0 wins first
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_q <= IDX_W'(NREQ - 1);
        end else if (update) begin
            last_q <= gnt_idx_c;
        end
    end

endmodule

// File: rtl/tcpc_reg_arbiter.sv
// Shares the single-ported TCPC register file among NREQ internal requesters.
module tcpc_reg_arbiter
    import tcpc_pkg::*;
#(
    parameter int unsigned NREQ           = 3,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NREQ-1:0]            REQ_VALID,
    input  logic [NREQ-1:0]            REQ_RNW,
    input  logic [REG_ADDR_W*NREQ-1:0] REQ_ADDR,
    input  logic [REG_DATA_W*NREQ-1:0] REQ_WDATA,
    output logic [NREQ-1:0]            DONE,
    output logic                       ERR,
    output logic [REG_DATA_W-1:0]      RDATA,
    output logic                       REQUEST,
    output logic                       RNW,
    output logic [REG_ADDR_W-1:0]      ADDR,
    output logic [REG_DATA_W-1:0]      WR_DATA,
    input  logic                       ACK,
    input  logic [REG_DATA_W-1:0]      RD_DATA
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_ISSUE = 2'(ST_ISSUE);
    localparam logic [1:0] S_WAIT  = 2'(ST_WAIT);
    localparam logic [1:0] S_DONE  = 2'(ST_DONE);

    logic [1:0]            state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [NREQ-1:0]       owner_q,   owner_d;
    reg_cmd_t              cmd_q,     cmd_d;
    logic                  request_q, request_d;
    logic [NREQ-1:0]       done_q,    done_d;
    logic                  err_q,     err_d;
    logic [REG_DATA_W-1:0] rdata_q,   rdata_d;

    logic                  arb_upd_c;
    logic [NREQ-1:0]       arb_gnt_c;
    logic [IDX_W-1:0]      arb_idx_c;
    reg_cmd_t              sel_cmd_c;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .CLK       (CLK),
        .RESET     (RESET),
        .req       (REQ_VALID),
        .update    (arb_upd_c),
        .gnt_c     (arb_gnt_c),
        .gnt_idx_c (arb_idx_c)
    );

    // Pick the granted requester's command fields
    always_comb begin
        sel_cmd_c.rnw   = REQ_RNW[arb_idx_c];
        sel_cmd_c.addr  = REQ_ADDR[32'(arb_idx_c) * REG_ADDR_W +: REG_ADDR_W];
        sel_cmd_c.wdata = REQ_WDATA[32'(arb_idx_c) * REG_DATA_W +: REG_DATA_W];
    end

    // Next-state and next-output logic for grant / issue / wait / done
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        cmd_d     = cmd_q;
        request_d = 1'b0;
        done_d    = '0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        arb_upd_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|REQ_VALID) begin
                    arb_upd_c = 1'b1;
                    owner_d   = arb_gnt_c;
                    cmd_d     = sel_cmd_c;
                    request_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ACK) begin
                    rdata_d = RD_DATA;
                    err_d   = 1'b0;
                    done_d  = owner_q;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    done_d  = owner_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            owner_q   <= '0;
            cmd_q     <= '0;
            request_q <= 1'b0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            cmd_q     <= cmd_d;
            request_q <= request_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign REQUEST = request_q;
    assign RNW     = cmd_q.rnw;
    assign ADDR    = cmd_q.addr;
    assign WR_DATA = cmd_q.wdata;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign RDATA   = rdata_q;

endmodule

// File: tb/tb_tcpc_reg_arbiter.sv
// Bench for tcpc_reg_arbiter with a small register-file model.
module tb_tcpc_reg_arbiter;

    localparam int NREQ = 3;
    localparam int TO   = 8;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [NREQ-1:0]   REQ_VALID, REQ_RNW;
    logic [8*NREQ-1:0] REQ_ADDR;
    logic [16*NREQ-1:0] REQ_WDATA;
    logic [NREQ-1:0]   DONE;
    logic              ERR;
    logic [15:0]       RDATA;
    logic              REQUEST, RNW;
    logic [7:0]        ADDR;
    logic [15:0]       WR_DATA;
    logic              ACK;
    logic [15:0]       RD_DATA;

    logic              rf_ack;
    logic              inj_ack;
    logic [15:0]       rf_rd;
    logic [15:0]       rf_mem  [256];
    logic [15:0]       ref_mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          port;
        logic        rnw;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [2:0]  exp_done;
        logic        exp_err;
        logic [15:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];
    int   rem[NREQ];
    int   start_c[NREQ];
    int   done_p[$];
    int   done_c[$];

    tcpc_reg_arbiter #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ_VALID (REQ_VALID),
        .REQ_RNW   (REQ_RNW),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .DONE      (DONE),
        .ERR       (ERR),
        .RDATA     (RDATA),
        .REQUEST   (REQUEST),
        .RNW       (RNW),
        .ADDR      (ADDR),
        .WR_DATA   (WR_DATA),
        .ACK       (ACK),
        .RD_DATA   (RD_DATA)
    );

    always #5 CLK = ~CLK;

    // Register file: 0x40-0x4F unmapped (never ACKs), others ACK one cycle after REQUEST
    function automatic logic mapped(input logic [7:0] a);
        return a[7:4] != 4'h4;
    endfunction

    initial begin
        for (int a = 0; a < 256; a++) rf_mem[a] <= {8'h5A, 8'(a)};
        rf_mem[8'h19] <= 16'h00A5;
    end

    always @(posedge CLK) begin
        rf_ack <= 1'b0;
        if (REQUEST && mapped(ADDR)) begin
            rf_ack <= 1'b1;
            rf_rd  <= rf_mem[ADDR];
            if (!RNW) rf_mem[ADDR] <= WR_DATA;
        end
    end

    assign ACK     = rf_ack | inj_ack;
    assign RD_DATA = rf_rd;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET     = 1'b1;
        REQ_VALID = '0;
        inj_ack   = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_request"}, 32'(REQUEST), 0);
        chk({nm, "_rnw"},     32'(RNW),     0);
        chk({nm, "_addr"},    32'(ADDR),    0);
        chk({nm, "_wr_data"}, 32'(WR_DATA), 0);
        chk({nm, "_done"},    32'(DONE),    0);
        chk({nm, "_err"},     32'(ERR),     0);
        chk({nm, "_rdata"},   32'(RDATA),   0);
    endtask

    // One isolated access; returns at the DONE cycle with REQ_VALID dropped
    task automatic access(input vec_t v, input string nm);
        int lat;
        REQ_VALID                  = '0;
        REQ_VALID[v.port]          = 1'b1;
        REQ_RNW[v.port]            = v.rnw;
        REQ_ADDR[v.port*8 +: 8]    = v.addr;
        REQ_WDATA[v.port*16 +: 16] = v.wdata;
        tick();
        chk({nm, "_request"}, 32'(REQUEST), 1);
        chk({nm, "_addr"},    32'(ADDR),    32'(v.addr));
        chk({nm, "_rnw"},     32'(RNW),     32'(v.rnw));
        if (!v.rnw) chk({nm, "_wr_data"}, 32'(WR_DATA), 32'(v.wdata));
        tick();
        chk({nm, "_request_pulse"}, 32'(REQUEST), 0);
        lat = 2;
        while (DONE == '0 && lat < 40) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat),  32'(v.exp_lat));
        chk({nm, "_done"},    32'(DONE), 32'(v.exp_done));
        chk({nm, "_err"},     32'(ERR),  32'(v.exp_err));
        if (v.rnw || v.exp_err) chk({nm, "_rdata"}, 32'(RDATA), 32'(v.exp_rd));
        REQ_VALID = '0;
    endtask

    // Requesters each hold REQ_VALID for rem[p] accesses starting at start_c[p]
    task automatic run_stream(input int n);
        int cyc;
        cyc = 0;
        done_p.delete();
        done_c.delete();
        for (int p = 0; p < NREQ; p++) begin
            REQ_RNW[p]         = 1'b1;
            REQ_ADDR[p*8 +: 8] = 8'(8'h20 + p);
        end
        while (done_p.size() < n && cyc < 100) begin
            for (int p = 0; p < NREQ; p++) REQ_VALID[p] = (rem[p] > 0) && (cyc >= start_c[p]);
            tick();
            cyc++;
            for (int p = 0; p < NREQ; p++) begin
                if (DONE[p]) begin
                    done_p.push_back(p);
                    done_c.push_back(cyc);
                    rem[p]--;
                end
            end
        end
        REQ_VALID = '0;
    endtask

    // Random traffic against a cycle-timeline model of the arbitration rules
    task automatic run_random(input int ncyc);
        int              k, m_g, m_last, m_req_c, m_done_c, m_next, r;
        logic            m_busy, m_err, m_rnw, found;
        logic [7:0]      m_addr, a;
        logic [15:0]     m_rd, m_wd;
        logic [NREQ-1:0] oh;
        k = 0; m_busy = 1'b0; m_last = NREQ - 1; m_next = 0;
        m_g = 0; m_req_c = -1; m_done_c = -1; m_err = 0; m_rnw = 0;
        m_addr = '0; m_rd = '0; m_wd = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = rf_mem[i];
        while (k < ncyc || ((m_busy || |REQ_VALID) && k < ncyc + 300)) begin
            if (m_busy && k == m_req_c) begin
                chk("rand_request", 32'(REQUEST), 1);
                chk("rand_addr",    32'(ADDR),    32'(m_addr));
                chk("rand_rnw",     32'(RNW),     32'(m_rnw));
                if (!m_rnw) chk("rand_wr_data", 32'(WR_DATA), 32'(m_wd));
            end else begin
                chk("rand_request_idle", 32'(REQUEST), 0);
            end
            if (m_busy && k == m_done_c) begin
                oh = '0;
                oh[m_g] = 1'b1;
                chk("rand_done", 32'(DONE), 32'(oh));
                chk("rand_err",  32'(ERR),  32'(m_err));
                if (m_rnw || m_err) chk("rand_rdata", 32'(RDATA), 32'(m_rd));
                REQ_VALID[m_g] = 1'b0;
                m_busy = 1'b0;
                m_next = k + 1;
            end else begin
                chk("rand_done_idle", 32'(DONE), 0);
            end
            if (k < ncyc) begin
                for (int p = 0; p < NREQ; p++) begin
                    if (!REQ_VALID[p] && $urandom_range(0, 3) == 0) begin
                        r = $urandom_range(0, 7);
                        a = (r == 0) ? (8'h40 | 8'($urandom_range(0, 15)))
                                     : (8'h20 | 8'($urandom_range(0, 7)));
                        REQ_VALID[p]          = 1'b1;
                        REQ_RNW[p]            = 1'($urandom_range(0, 1));
                        REQ_ADDR[p*8 +: 8]    = a;
                        REQ_WDATA[p*16 +: 16] = 16'($urandom);
                    end
                end
            end
            if (!m_busy && k >= m_next && |REQ_VALID) begin
                found = 1'b0;
                for (int i = 1; i <= NREQ; i++) begin
                    if (!found && REQ_VALID[(m_last + i) % NREQ]) begin
                        found = 1'b1;
                        m_g   = (m_last + i) % NREQ;
                    end
                end
                m_last   = m_g;
                m_busy   = 1'b1;
                m_rnw    = REQ_RNW[m_g];
                m_addr   = REQ_ADDR[m_g*8 +: 8];
                m_wd     = REQ_WDATA[m_g*16 +: 16];
                m_req_c  = k + 1;
                m_err    = !mapped(m_addr);
                m_done_c = m_err ? k + 3 + TO : k + 3;
                m_rd     = m_err ? 16'h0000 : ref_mem[m_addr];
                if (!m_err && !m_rnw) ref_mem[m_addr] = m_wd;
            end
            tick();
            k++;
        end
    endtask

    initial begin
        vec_t v;
        int   exp_rr[6];
        int   exp_101[3];

        // port, rnw, addr, wdata, exp DONE, exp ERR, exp RDATA, exp latency
        vecs[0] = '{0, 1'b1, 8'h19, 16'h0000, 3'b001, 1'b0, 16'h00A5, 3};
        vecs[1] = '{2, 1'b0, 8'h51, 16'h001C, 3'b100, 1'b0, 16'h0000, 3};
        vecs[2] = '{1, 1'b1, 8'h40, 16'h0000, 3'b010, 1'b1, 16'h0000, 3 + TO};
        vecs[3] = '{1, 1'b1, 8'h51, 16'h0000, 3'b010, 1'b0, 16'h001C, 3};
        vecs[4] = '{0, 1'b0, 8'h10, 16'h1234, 3'b001, 1'b0, 16'h0000, 3};
        vecs[5] = '{2, 1'b1, 8'h10, 16'h0000, 3'b100, 1'b0, 16'h1234, 3};
        vecs[6] = '{2, 1'b0, 8'h40, 16'h5555, 3'b100, 1'b1, 16'h0000, 3 + TO};
        exp_rr  = '{0, 1, 2, 0, 1, 2};
        exp_101 = '{1, 0, 1};

        REQ_VALID = '0; REQ_RNW = '0; REQ_ADDR = '0; REQ_WDATA = '0;
        inj_ack = 1'b0;
        do_reset();
        chk_reset_vals("reset");

        // Isolated accesses from the table
        for (int i = 0; i < 7; i++) begin
            access(vecs[i], $sformatf("vec%0d", i));
            tick();
            chk($sformatf("vec%0d_done_clear", i), 32'(DONE), 0);
        end
        chk("rf_reg_51", 32'(rf_mem[8'h51]), 32'h001C);
        chk("rf_reg_10", 32'(rf_mem[8'h10]), 32'h1234);

        // Timeout followed by a late ACK while idle
        v = '{1, 1'b1, 8'h4F, 16'h0000, 3'b010, 1'b1, 16'h0000, 3 + TO};
        access(v, "late");
        tick();
        inj_ack = 1'b1;
        chk("late_d1_done", 32'(DONE), 0);
        tick();
        inj_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("late_done", 32'(DONE), 0);
            chk("late_request", 32'(REQUEST), 0);
            tick();
        end

        // Reset during WAIT, ACK in the following cycle
        do_reset();
        REQ_VALID = 3'b010;
        REQ_RNW[1] = 1'b1; REQ_ADDR[15:8] = 8'h40; REQ_WDATA[31:16] = 16'hBEEF;
        tick();
        chk("rstw_issue", 32'(REQUEST), 1);
        tick();
        tick();
        RESET = 1'b1;
        REQ_VALID = '0;
        tick();
        RESET = 1'b0;
        inj_ack = 1'b1;
        chk_reset_vals("rstw");
        REQ_RNW = 3'b111;
        REQ_ADDR = {8'h21, 8'h20, 8'h19};
        REQ_VALID = 3'b111;
        tick();
        inj_ack = 1'b0;
        chk("rstw_grant_req",  32'(REQUEST), 1);
        chk("rstw_grant_addr", 32'(ADDR), 32'h19);
        chk("rstw_done_c5",    32'(DONE), 0);
        tick();
        chk("rstw_done_c6",    32'(DONE), 0);
        tick();
        chk("rstw_done_port0", 32'(DONE), 32'b001);
        chk("rstw_rdata",      32'(RDATA), 32'h00A5);
        REQ_VALID = '0;
        tick();
        chk("rstw_done_clear", 32'(DONE), 0);

        // All three requesters continuously valid from reset
        do_reset();
        rem = '{2, 2, 2};
        start_c = '{0, 0, 0};
        run_stream(6);
        chk("rr_count", 32'(done_p.size()), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < done_p.size()) begin
                chk($sformatf("rr_order%0d", i), 32'(done_p[i]), 32'(exp_rr[i]));
                chk($sformatf("rr_cycle%0d", i), 32'(done_c[i]), 32'(3 + 4 * i));
            end
        end

        // Port 1 holds valid for two accesses, port 0 joins mid-stream
        do_reset();
        rem = '{1, 2, 0};
        start_c = '{2, 0, 0};
        run_stream(3);
        chk("mix_count", 32'(done_p.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < done_p.size()) begin
                chk($sformatf("mix_order%0d", i), 32'(done_p[i]), 32'(exp_101[i]));
                chk($sformatf("mix_cycle%0d", i), 32'(done_c[i]), 32'(3 + 4 * i));
            end
        end

        // Random traffic
        do_reset();
        run_random(1500);
        chk("rand_drained", 32'(REQ_VALID), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tcpc_reg_arbiter.md
# tcpc_reg_arbiter

Shares the single-ported TCPC register file (REQUEST/RNW/ADDR/WR_DATA → ACK/RD_DATA) among several internal requesters. Typical clients are the I2C host slave, the PD protocol engine and the Type-C port manager. Each access is a single transaction: grant, one-cycle REQUEST pulse, wait for ACK, return. A timeout produces an error completion when the register file never ACKs, which happens for unmapped addresses or writes to read-only registers. The block sits directly in front of the register file and is its only master.

## Interface
Parameters:
- NREQ, 3: number of requesters, 2..8
- TIMEOUT_CYCLES, 8: cycles in WAIT without ACK before error completion, ≥2

Ports:
- CLK  in  1  clock; single clock domain
- RESET  in  1  synchronous, active-high reset
- REQ_VALID  in  NREQ  per-requester request; held with its fields until DONE
- REQ_RNW  in  NREQ  1 = read, 0 = write
- REQ_ADDR  in  8*NREQ  register address, requester i at [8i+7:8i]
- REQ_WDATA  in  16*NREQ  write data, requester i at [16i+15:16i]
- DONE  out  NREQ  one-cycle completion pulse, one-hot
- ERR  out  1  qualifies DONE: 1 = timeout, no ACK
- RDATA  out  16  read data, valid while DONE is high
- REQUEST  out  1  to register file
- RNW  out  1  to register file
- ADDR  out  8  to register file
- WR_DATA  out  16  to register file
- ACK  in  1  from register file, registered one-cycle pulse
- RD_DATA  in  16  from register file, valid with ACK

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any REQ_VALID, latch the granted index g and register RNW/ADDR/WR_DATA from requester g. Go to ISSUE. Otherwise stay.
- ISSUE: REQUEST=1 for exactly this cycle; clear the timeout counter; go to WAIT. REQUEST is never held, because the register file ACKs every cycle REQUEST is sampled high.
- WAIT: REQUEST=0.
  - ACK=1: capture RD_DATA into RDATA (writes also capture; value is don't-care), ERR=0, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, set RDATA=16'h0000, ERR=1, go to DONE.
- DONE: DONE[g]=1 for this cycle only; REQ_VALID is ignored; go to IDLE.
- Arbitration is round-robin. The pointer `last` holds the previously granted index. Grant goes to the first valid index in last+1, last+2, … modulo NREQ. `last` updates on grant.
- ACK in IDLE, ISSUE or DONE is ignored. This covers stray or late ACKs after a timeout or a reset.
- The RNW/ADDR/WR_DATA outputs hold their latched values until the next grant.
- A requester that keeps REQ_VALID high in the cycle after DONE is treated as issuing a new request.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

## Timing
- Reset values:
  - State = IDLE, `last` = NREQ-1, so port 0 wins first.
  - REQUEST, RNW, DONE, ERR = 0.
  - ADDR = 8'h00, WR_DATA = 16'h0000, RDATA = 16'h0000.
  - Counter = 0.
- RESET in any state returns to IDLE on the next edge with all outputs at reset values. No DONE is issued for the aborted access.
- Nominal access, with REQ_VALID first sampled high at the end of cycle c:
  - Cycle c+1: REQUEST=1.
  - Cycle c+2: register file ACK.
  - Cycle c+3: DONE and RDATA.
  - Next grant is sampled at the end of cycle c+4 at the earliest, giving 4 cycles per access back-to-back.
- Timeout access: DONE with ERR=1 appears in cycle c+3+TIMEOUT_CYCLES.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package tcpc_pkg:
  - state enum (IDLE/ISSUE/WAIT/DONE)
  - TCPC register address constants (e.g. ADDR_ALERT=8'h10, ADDR_TCPC_CONTROL=8'h19, ADDR_TRANSMIT=8'h50)
  - REG_DATA_W=16 and REG_ADDR_W=8
- One sub-module, rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector and an update strobe.
  - Outputs: one-hot grant plus binary index; owns the `last` pointer.
- Datapath muxing and the FSM stay in the top module.

## Test plan
- Single read, port 0, ADDR=8'h19: the register file model ACKs one cycle after REQUEST with 16'h00A5. Expect REQUEST high for 1 cycle at c+1, DONE=3'b001 at c+3, RDATA=16'h00A5, ERR=0.
- Single write, port 2, ADDR=8'h51, WDATA=16'h001C: expect WR_DATA=16'h001C and RNW=0 during REQUEST, DONE=3'b100, and the model register updated to 8'h1C.
- All three ports valid continuously from reset: expect grant order 0,1,2,0,1,2, with each DONE spaced 4 cycles apart.
- Read of unmapped ADDR=8'h40 with TIMEOUT_CYCLES=8: no ACK. Expect DONE with ERR=1 and RDATA=16'h0000 exactly 11 cycles after VALID is sampled. A late ACK injected the following cycle is ignored: no extra DONE, and the FSM stays in IDLE.
- RESET asserted during WAIT with ACK arriving the next cycle: expect no DONE, all outputs at reset values, and the next request granted to port 0.
- Port 1 keeps REQ_VALID high for two accesses while port 0 requests once, mid-stream: expect order 1,0,1 with no starvation.
